// File: rtl/local_inject_ctrl.sv
// ---------------------------------------------------------------------------
// local_inject_ctrl
//
// Purpose: buffers flits offered by the processing element (PE) and injects
// them one at a time into the router local input. Each flit is presented for
// one cycle (SEND). In the following cycle (CHECK) the router reports whether
// the flit won a channel. If it did not, the same head flit is presented again,
// so FIFO order is strictly preserved. All-zero flits mean "no flit". They are
// accepted and then discarded.
//
// Optional feature: macro INJ_STARVE_THROTTLE_EN builds a starvation counter.
// When the macro is not defined, starve is tied to 0.
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous, active-low reset
//   pe_valid   in   PE offers a flit this cycle
//   pe_ready   out  FIFO can accept a flit (occupancy < DEPTH)
//   pe_flit    in   flit from PE (`WIDTH_PORT bits, zero = no flit)
//   pe_pv      in   productive vector for pe_flit (`WIDTH_PV bits)
//   dinLocal   out  flit to router local input, zero when idle (registered)
//   PVLocal    out  productive vector for dinLocal, zero when idle (registered)
//   inj_ack    in   router accepted the flit presented in the previous cycle
//   starve     out  local injection is starving (registered)
//   occupancy  out  entries held, including the in-flight head
// ---------------------------------------------------------------------------
`ifndef WIDTH_PORT
`define WIDTH_PORT 32
`endif
`ifndef WIDTH_PV
`define WIDTH_PV 4
`endif

module local_inject_ctrl #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pe_valid,
    output logic                    pe_ready,
    input  logic [`WIDTH_PORT-1:0]  pe_flit,
    input  logic [`WIDTH_PV-1:0]    pe_pv,
    output logic [`WIDTH_PORT-1:0]  dinLocal,
    output logic [`WIDTH_PV-1:0]    PVLocal,
    input  logic                    inj_ack,
    output logic                    starve,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = `WIDTH_PV + `WIDTH_PORT;
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW:0]     occ_q, occ_d;
    logic [PW:0]     occ_rem;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   out_q, out_d;
    logic            push_store;
    logic            pop;

    assign pe_ready            = (occ_q < DEPTH_C);
    assign occupancy           = occ_q;
    assign {PVLocal, dinLocal} = out_q;

    always_comb begin
        // Zero flits complete the handshake but are never stored.
        push_store = pe_valid && pe_ready && (pe_flit != '0);
        // inj_ack only has meaning for the flit presented one cycle earlier.
        pop        = (state_q == CHECK) && inj_ack;
        rd_d       = rd_q + PW'(pop);
        wr_d       = wr_q + PW'(push_store);
        occ_rem    = occ_q - (PW+1)'(pop);
        occ_d      = occ_rem + (PW+1)'(push_store);

        state_d = state_q;
        case (state_q)
            IDLE:    if (occ_d != '0) state_d = SEND;
            SEND:    state_d = CHECK;
            CHECK:   state_d = (occ_d != '0) ? SEND : IDLE;
            default: state_d = IDLE;
        endcase

        // Pre-compute the flit for the next SEND cycle so that it leaves from a
        // flop. If nothing is left after this edge's pop, the head is the flit
        // being pushed at this same edge. This gives the one-cycle fall-through
        // from an empty FIFO.
        out_d = '0;
        if (state_d == SEND) begin
            out_d = (occ_rem == '0) ? {pe_pv, pe_flit} : mem_q[rd_d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            occ_q   <= occ_d;
            out_q   <= out_d;
        end
    end

    // Storage is left unreset. The pointers and occupancy decide what is valid.
    always_ff @(posedge clk) begin
        if (push_store) begin
            mem_q[wr_q] <= {pe_pv, pe_flit};
        end
    end

`ifdef INJ_STARVE_THROTTLE_EN
    localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

    logic [7:0] cnt_q, cnt_d;
    logic       starve_q;

    always_comb begin
        cnt_d = cnt_q;
        if (occ_q == '0) begin
            cnt_d = '0;
        end else if (state_q == CHECK) begin
            if (inj_ack) begin
                cnt_d = '0;
            end else if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            starve_q <= (cnt_d >= LIMIT_C);
        end
    end

    assign starve = starve_q;
`else
    // The limit has no effect when the throttle is not built.
    logic [7:0] limit_unused;
    assign limit_unused = 8'(STARVE_LIMIT);
    assign starve       = 1'b0;
`endif

endmodule

// File: tb/tb_local_inject_ctrl.sv
`ifndef WIDTH_PORT
`define WIDTH_PORT 32
`endif
`ifndef WIDTH_PV
`define WIDTH_PV 4
`endif

module tb_local_inject_ctrl;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;
    localparam int FW    = `WIDTH_PORT;
    localparam int PV    = `WIDTH_PV;
`ifdef INJ_STARVE_THROTTLE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   pe_valid;
    logic                   pe_ready;
    logic [FW-1:0]          pe_flit;
    logic [PV-1:0]          pe_pv;
    logic [FW-1:0]          dinLocal;
    logic [PV-1:0]          PVLocal;
    logic                   inj_ack;
    logic                   starve;
    logic [$clog2(DEPTH):0] occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    local_inject_ctrl #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .pe_valid  (pe_valid),
        .pe_ready  (pe_ready),
        .pe_flit   (pe_flit),
        .pe_pv     (pe_pv),
        .dinLocal  (dinLocal),
        .PVLocal   (PVLocal),
        .inj_ack   (inj_ack),
        .starve    (starve),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] fl(input int i);
        return FW'(32'hA000_0000 + i + 1);
    endfunction

    function automatic logic [PV-1:0] pvf(input int i);
        return PV'(1 << (i % PV));
    endfunction

    // ------------------------------------------------------------------
    // Reference model: a queue of waiting flits plus a phase
    // (0 = nothing shown, 1 = head shown this cycle, 2 = awaiting the
    // router verdict on the head shown last cycle).
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [PV-1:0] pv;
        logic [FW-1:0] f;
    } ent_t;

    ent_t mq[$];
    int   m_phase  = 0;
    int   m_cnt    = 0;
    bit   m_starve = 1'b0;

    initial begin : model
        int sz;
        bit rdy;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                mq.delete();
                m_phase  = 0;
                m_cnt    = 0;
                m_starve = 1'b0;
            end else begin
                sz  = mq.size();
                rdy = (sz < DEPTH);
                if (m_phase == 2 && inj_ack) void'(mq.pop_front());
                if (pe_valid && rdy && pe_flit != '0) mq.push_back({pe_pv, pe_flit});
                if (STARVE_ON) begin
                    if (sz == 0) m_cnt = 0;
                    else if (m_phase == 2) m_cnt = inj_ack ? 0 : ((m_cnt < 255) ? m_cnt + 1 : 255);
                    m_starve = (m_cnt >= LIMIT);
                end
                m_phase = (m_phase == 1) ? 2 : ((mq.size() != 0) ? 1 : 0);
            end
        end
    end

    initial begin : compare
        ent_t e;
        forever begin
            @(negedge clk);
            e = (m_phase == 1 && mq.size() != 0) ? mq[0] : '0;
            chk("m_dinLocal",  64'(dinLocal),  64'(e.f));
            chk("m_PVLocal",   64'(PVLocal),   64'(e.pv));
            chk("m_occupancy", 64'(occupancy), 64'(mq.size()));
            chk("m_pe_ready",  64'(pe_ready),  64'(mq.size() < DEPTH));
            chk("m_starve",    64'(starve),    64'(m_starve));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    logic [FW-1:0] seen[$];
    int            pat[5] = '{0, 1, 0, 1, 1};

    initial begin : stim
        int  guard;
        bit  acc;
        int  pidx;
        bit  prev_nz, cur_nz, in_check;

        reset = 1'b0; pe_valid = 1'b0; pe_flit = '0; pe_pv = '0; inj_ack = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        step();
        chk("rst_occupancy", 64'(occupancy), 64'(0));
        chk("rst_pe_ready",  64'(pe_ready),  64'(1));
        chk("rst_dinLocal",  64'(dinLocal),  64'(0));
        chk("rst_starve",    64'(starve),    64'(0));

        // Single flit, ack held high (ignored in SEND, pops in CHECK)
        pe_valid = 1'b1; pe_flit = FW'(32'h1234_56A5); pe_pv = PV'(1); inj_ack = 1'b1;
        step();
        pe_valid = 1'b0; pe_flit = '0; pe_pv = '0;
        chk("s1_din_c1", 64'(dinLocal),  64'(FW'(32'h1234_56A5)));
        chk("s1_pv_c1",  64'(PVLocal),   64'(1));
        chk("s1_occ_c1", 64'(occupancy), 64'(1));
        step();
        chk("s1_din_c2", 64'(dinLocal),  64'(0));
        chk("s1_occ_c2", 64'(occupancy), 64'(1));
        step();
        chk("s1_occ_c3", 64'(occupancy), 64'(0));
        chk("s1_din_c3", 64'(dinLocal),  64'(0));
        inj_ack = 1'b0;
        step();
        chk("s1_din_idle", 64'(dinLocal), 64'(0));

        // Five back-to-back offers with ack low: fill, hold the fifth
        for (int j = 0; j < 8; j++) begin
            pe_valid = 1'b1;
            pe_flit  = fl((j < 4) ? j : 4);
            pe_pv    = pvf((j < 4) ? j : 4);
            chk("s2_ready", 64'(pe_ready), 64'(j < 4));
            step();
            chk("s2_din", 64'(dinLocal), (j % 2 == 0) ? 64'(fl(0)) : 64'(0));
            chk("s2_pv",  64'(PVLocal),  (j % 2 == 0) ? 64'(pvf(0)) : 64'(0));
            chk("s2_occ", 64'(occupancy), 64'((j < 4) ? j + 1 : 4));
        end
        inj_ack = 1'b1;
        seen.delete();
        guard = 0;
        while ((pe_valid || occupancy != 0) && guard < 100) begin
            acc = pe_valid && pe_ready;
            step();
            if (acc) begin pe_valid = 1'b0; pe_flit = '0; pe_pv = '0; end
            if (dinLocal != '0) seen.push_back(dinLocal);
            guard++;
        end
        chk("s2_drain_in_time", 64'(guard < 100), 64'(1));
        chk("s2_seen_count", 64'(seen.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            chk("s2_order", (i < seen.size()) ? 64'(seen[i]) : 64'(0), 64'(fl(i + 1)));
        inj_ack = 1'b0;
        step();

        // Three flits, ack pattern 0,1,0,1,1 on CHECK cycles
        seen.delete();
        pidx = 0; prev_nz = 1'b0; cur_nz = 1'b0;
        for (int c = 0; c < 30; c++) begin
            in_check = prev_nz;
            inj_ack  = (in_check && pidx < 5) ? (pat[pidx] != 0) : 1'b0;
            if (in_check && pidx < 5) pidx++;
            if (c < 3) begin
                pe_valid = 1'b1; pe_flit = fl(10 + c); pe_pv = pvf(c);
            end else begin
                pe_valid = 1'b0; pe_flit = '0; pe_pv = '0;
            end
            step();
            prev_nz = cur_nz;
            cur_nz  = (dinLocal != '0);
            if (cur_nz) seen.push_back(dinLocal);
        end
        inj_ack = 1'b0;
        chk("s3_seen_count", 64'(seen.size()), 64'(5));
        chk("s3_exit0", (seen.size() > 0) ? 64'(seen[0]) : 64'(0), 64'(fl(10)));
        chk("s3_exit1", (seen.size() > 1) ? 64'(seen[1]) : 64'(0), 64'(fl(10)));
        chk("s3_exit2", (seen.size() > 2) ? 64'(seen[2]) : 64'(0), 64'(fl(11)));
        chk("s3_exit3", (seen.size() > 3) ? 64'(seen[3]) : 64'(0), 64'(fl(11)));
        chk("s3_exit4", (seen.size() > 4) ? 64'(seen[4]) : 64'(0), 64'(fl(12)));
        chk("s3_occ_end", 64'(occupancy), 64'(0));

        // Starvation: ack low for three CHECKs, then high
        pe_valid = 1'b1; pe_flit = fl(20); pe_pv = pvf(0); inj_ack = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            step();
            pe_valid = 1'b0; pe_flit = '0; pe_pv = '0;
            chk("s4_starve", 64'(starve), 64'(STARVE_ON && (c == 7 || c == 8)));
            if (c == 7) inj_ack = 1'b1;
        end
        chk("s4_occ_end", 64'(occupancy), 64'(0));
        inj_ack = 1'b0;
        step();

        // Reset while presenting with two entries held
        pe_valid = 1'b1; pe_flit = fl(30); pe_pv = pvf(1);
        step();
        pe_flit = fl(31); pe_pv = pvf(2);
        step();
        pe_valid = 1'b0; pe_flit = '0; pe_pv = '0;
        step();
        chk("s5_din_before", 64'(dinLocal),  64'(fl(30)));
        chk("s5_occ_before", 64'(occupancy), 64'(2));
        #2 reset = 1'b0;
        #1;
        chk("s5_din_async", 64'(dinLocal),  64'(0));
        chk("s5_pv_async",  64'(PVLocal),   64'(0));
        chk("s5_occ_async", 64'(occupancy), 64'(0));
        @(posedge clk);
        #3 reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("s5_din_after",   64'(dinLocal),  64'(0));
            chk("s5_occ_after",   64'(occupancy), 64'(0));
            chk("s5_ready_after", 64'(pe_ready),  64'(1));
        end

        // Zero flit offered: accepted and dropped
        pe_valid = 1'b1; pe_flit = '0; pe_pv = PV'(3);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("s6_occ", 64'(occupancy), 64'(0));
            chk("s6_din", 64'(dinLocal),  64'(0));
            chk("s6_pv",  64'(PVLocal),   64'(0));
        end
        pe_valid = 1'b0; pe_pv = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
